// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - width derivation helpers shared by the flow width converter
package flow_pkg;

  // Counter width for an index running 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Narrow-side width: the lane every wide word is cut into.
  function automatic int lane_w(input int in_w, input int out_w);
    return (in_w < out_w) ? in_w : out_w;
  endfunction

  // Number of narrow lanes per wide word.
  function automatic int ratio(input int in_w, input int out_w);
    return ((in_w > out_w) ? in_w : out_w) / lane_w(in_w, out_w);
  endfunction

  // Width of the destination lane-valid mask.
  function automatic int keep_w(input int in_w, input int out_w);
    return out_w / lane_w(in_w, out_w);
  endfunction

endpackage

// File: rtl/flow_width_conv_if.sv
// rtl/flow_width_conv_if.sv - valid/ready stream bundle with last and lane keep
interface flow_width_conv_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = 1
);
  logic              val;
  logic              rdy;
  logic [DATA_W-1:0] data;
  logic              last;
  logic [KEEP_W-1:0] keep;

  modport master (output val, output data, output last, output keep, input rdy);
  modport slave  (input val, input data, input last, input keep, output rdy);
endinterface

// File: rtl/flow_lane_sel.sv
// rtl/flow_lane_sel.sv - maps a beat index to a lane write-enable and slice
module flow_lane_sel #(
  parameter int LANE_W    = 8,
  parameter int RATIO     = 2,
  parameter int IDX_W     = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [IDX_W-1:0]        idx,
  input  logic [LANE_W*RATIO-1:0] wide,
  output logic [RATIO-1:0]        lane_we,
  output logic [LANE_W-1:0]       slice
);

  int lane;

  // Beat 0 lands in the low lane when LSB_FIRST, otherwise in the high lane.
  assign lane = LSB_FIRST ? int'(idx) : (RATIO - 1 - int'(idx));

  // One-hot lane enable for the upsizer and slice mux for the downsizer.
  always_comb begin
    lane_we = '0;
    slice   = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (l == lane) begin
        lane_we[l] = 1'b1;
        slice      = wide[l*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/flow_width_conv.sv
// rtl/flow_width_conv.sv - parametrised valid/ready upsizer/downsizer with last and keep
module flow_width_conv
  import flow_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  input logic               cfg_en,
  flow_width_conv_if.slave  src,
  flow_width_conv_if.master dst
);

  localparam int LANE_W = lane_w(IN_W, OUT_W);
  localparam int RATIO  = ratio(IN_W, OUT_W);
  localparam int KEEP_W = keep_w(IN_W, OUT_W);
  localparam int IDX_W  = clog2_min1(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Source keep carries no meaning on the narrow/wide input side.
  logic unused_src_keep;
  assign unused_src_keep = ^src.keep;

  if ((IN_W == OUT_W) ||
      (((IN_W > OUT_W) ? (IN_W % OUT_W) : (OUT_W % IN_W)) != 0)) begin : g_bad_widths
    $error("flow_width_conv: IN_W and OUT_W must differ and be integer multiples");
  end else if (IN_W < OUT_W) begin : g_up
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RATIO-1:0]  keep_acc_q, keep_acc_d;
    logic [OUT_W-1:0]  acc_q, acc_d, acc_next;
    logic              dst_val_q, dst_val_d;
    logic [OUT_W-1:0]  dst_data_q, dst_data_d;
    logic              dst_last_q, dst_last_d;
    logic [KEEP_W-1:0] dst_keep_q, dst_keep_d;
    logic [RATIO-1:0]  lane_we;
    logic [LANE_W-1:0] unused_slice;
    logic              src_rdy, src_fire, dst_fire, complete;

    flow_lane_sel #(
      .LANE_W(LANE_W), .RATIO(RATIO), .IDX_W(IDX_W), .LSB_FIRST(LSB_FIRST)
    ) u_lane_sel (
      .idx(idx_q), .wide(acc_q), .lane_we(lane_we), .slice(unused_slice)
    );

    // Accept only when the output register is free or emptying this cycle.
    assign src_rdy  = !rst && cfg_en && (!dst_val_q || dst.rdy);
    assign src_fire = src.val && src_rdy;
    assign dst_fire = dst_val_q && dst.rdy;
    assign complete = src_fire && ((idx_q == LAST_IDX) || src.last);

    // Accumulator contents with the current beat merged into its lane.
    always_comb begin
      acc_next = acc_q;
      for (int l = 0; l < RATIO; l++) begin
        if (lane_we[l]) acc_next[l*LANE_W +: LANE_W] = src.data;
      end
    end

    // Pack beats; a completing beat moves the whole word to the output register.
    always_comb begin
      idx_d      = idx_q;
      keep_acc_d = keep_acc_q;
      acc_d      = acc_q;
      dst_val_d  = dst_val_q;
      dst_data_d = dst_data_q;
      dst_last_d = dst_last_q;
      dst_keep_d = dst_keep_q;
      if (dst_fire) dst_val_d = 1'b0;
      if (src_fire) begin
        if (complete) begin
          dst_val_d  = 1'b1;
          dst_data_d = acc_next;
          dst_last_d = src.last;
          dst_keep_d = keep_acc_q | lane_we;
          acc_d      = '0;
          keep_acc_d = '0;
          idx_d      = '0;
        end else begin
          acc_d      = acc_next;
          keep_acc_d = keep_acc_q | lane_we;
          idx_d      = idx_q + 1'b1;
        end
      end
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        idx_q      <= '0;
        keep_acc_q <= '0;
        acc_q      <= '0;
        dst_val_q  <= 1'b0;
        dst_data_q <= '0;
        dst_last_q <= 1'b0;
        dst_keep_q <= '0;
      end else begin
        idx_q      <= idx_d;
        keep_acc_q <= keep_acc_d;
        acc_q      <= acc_d;
        dst_val_q  <= dst_val_d;
        dst_data_q <= dst_data_d;
        dst_last_q <= dst_last_d;
        dst_keep_q <= dst_keep_d;
      end
    end

    assign src.rdy  = src_rdy;
    assign dst.val  = dst_val_q;
    assign dst.data = dst_data_q;
    assign dst.last = dst_last_q;
    assign dst.keep = dst_keep_q;
  end else begin : g_down
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IN_W-1:0]   hold_q, hold_d;
    logic              held_last_q, held_last_d;
    logic              busy_q, busy_d;
    logic [RATIO-1:0]  unused_we;
    logic [LANE_W-1:0] slice;
    logic              src_rdy, src_fire, dst_fire, at_last;

    flow_lane_sel #(
      .LANE_W(LANE_W), .RATIO(RATIO), .IDX_W(IDX_W), .LSB_FIRST(LSB_FIRST)
    ) u_lane_sel (
      .idx(idx_q), .wide(hold_q), .lane_we(unused_we), .slice(slice)
    );

    // A new word may load on the same edge the final slice leaves.
    assign at_last  = (idx_q == LAST_IDX);
    assign src_rdy  = !rst && cfg_en && (!busy_q || (dst.rdy && at_last));
    assign src_fire = src.val && src_rdy;
    assign dst_fire = busy_q && dst.rdy;

    // Step through slices; an incoming word restarts at slice 0.
    always_comb begin
      idx_d       = idx_q;
      hold_d      = hold_q;
      held_last_d = held_last_q;
      busy_d      = busy_q;
      if (dst_fire) begin
        if (at_last) begin
          idx_d  = '0;
          busy_d = 1'b0;
        end else begin
          idx_d  = idx_q + 1'b1;
        end
      end
      if (src_fire) begin
        hold_d      = src.data;
        held_last_d = src.last;
        busy_d      = 1'b1;
        idx_d       = '0;
      end
    end

    // State registers; reset drops a word mid-split.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        idx_q       <= '0;
        hold_q      <= '0;
        held_last_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        idx_q       <= idx_d;
        hold_q      <= hold_d;
        held_last_q <= held_last_d;
        busy_q      <= busy_d;
      end
    end

    assign src.rdy  = src_rdy;
    assign dst.val  = busy_q;
    assign dst.data = slice;
    assign dst.last = held_last_q && at_last;
    assign dst.keep = {KEEP_W{busy_q}};
  end

endmodule

// File: tb/tb_flow_width_conv.sv
// tb/tb_flow_width_conv.sv - directed self-checking bench for flow_width_conv
module tb_flow_width_conv;

  logic clk = 1'b0;
  logic rst;
  logic en0, en1, en2, en3;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  flow_width_conv_if #(.DATA_W(8),  .KEEP_W(1)) s0();
  flow_width_conv_if #(.DATA_W(16), .KEEP_W(2)) d0();
  flow_width_conv_if #(.DATA_W(8),  .KEEP_W(1)) s1();
  flow_width_conv_if #(.DATA_W(16), .KEEP_W(2)) d1();
  flow_width_conv_if #(.DATA_W(16), .KEEP_W(1)) s2();
  flow_width_conv_if #(.DATA_W(8),  .KEEP_W(1)) d2();
  flow_width_conv_if #(.DATA_W(32), .KEEP_W(1)) s3();
  flow_width_conv_if #(.DATA_W(8),  .KEEP_W(1)) d3();

  flow_width_conv #(.IN_W(8),  .OUT_W(16), .LSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .cfg_en(en0), .src(s0), .dst(d0));
  flow_width_conv #(.IN_W(8),  .OUT_W(16), .LSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .cfg_en(en1), .src(s1), .dst(d1));
  flow_width_conv #(.IN_W(16), .OUT_W(8),  .LSB_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .cfg_en(en2), .src(s2), .dst(d2));
  flow_width_conv #(.IN_W(32), .OUT_W(8),  .LSB_FIRST(1'b1)) u3 (.clk(clk), .rst(rst), .cfg_en(en3), .src(s3), .dst(d3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0]  exp_q[$];
  logic [8:0]  exp_v;
  logic [31:0] w;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic        stalled, src_go, dst_go;
  int          sent, got, cyc;

  initial begin
    rst = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
    s0.val = 0; s0.data = 0; s0.last = 0; s0.keep = 1; d0.rdy = 1;
    s1.val = 0; s1.data = 0; s1.last = 0; s1.keep = 1; d1.rdy = 1;
    s2.val = 0; s2.data = 0; s2.last = 0; s2.keep = 1; d2.rdy = 1;
    s3.val = 0; s3.data = 0; s3.last = 0; s3.keep = 1; d3.rdy = 1;
    repeat (2) tick();

    chk("rst_u0_src_rdy", s0.rdy, 0);
    chk("rst_u0_dst_val", d0.val, 0);
    chk("rst_u0_dst_data", d0.data, 0);
    chk("rst_u0_dst_last", d0.last, 0);
    chk("rst_u0_dst_keep", d0.keep, 0);
    chk("rst_u2_src_rdy", s2.rdy, 0);
    chk("rst_u2_dst_val", d2.val, 0);
    chk("rst_u2_dst_keep", d2.keep, 0);
    rst = 1'b0;
    #1;

    // upsize LSB first: 0x11, 0x22(last)
    s0.val = 1; s0.data = 8'h11; s0.last = 0;
    #1 chk("up_src_rdy", s0.rdy, 1);
    tick();
    s0.data = 8'h22; s0.last = 1;
    #1 chk("up_no_early_val", d0.val, 0);
    tick();
    s0.val = 0; s0.last = 0;
    #1;
    chk("up_val", d0.val, 1);
    chk("up_data", d0.data, 16'h2211);
    chk("up_keep", d0.keep, 2'b11);
    chk("up_last", d0.last, 1);
    tick();
    chk("up_val_drop", d0.val, 0);

    // upsize MSB first, single beat with last
    s1.val = 1; s1.data = 8'hAA; s1.last = 1;
    tick();
    s1.val = 0; s1.last = 0;
    #1;
    chk("msb_val", d1.val, 1);
    chk("msb_data", d1.data, 16'hAA00);
    chk("msb_keep", d1.keep, 2'b10);
    chk("msb_last", d1.last, 1);
    tick();

    // downsize 16->8 back-to-back words
    s2.val = 1; s2.data = 16'hBEEF; s2.last = 0;
    tick();
    s2.data = 16'h1234; s2.last = 1;
    #1;
    chk("dn_c1_val", d2.val, 1);
    chk("dn_c1_data", d2.data, 8'hEF);
    chk("dn_c1_last", d2.last, 0);
    chk("dn_c1_rdy", s2.rdy, 0);
    tick();
    chk("dn_c2_data", d2.data, 8'hBE);
    chk("dn_c2_last", d2.last, 0);
    chk("dn_c2_rdy", s2.rdy, 1);
    tick();
    s2.val = 0; s2.last = 0;
    #1;
    chk("dn_c3_data", d2.data, 8'h34);
    chk("dn_c3_last", d2.last, 0);
    tick();
    chk("dn_c4_val", d2.val, 1);
    chk("dn_c4_data", d2.data, 8'h12);
    chk("dn_c4_last", d2.last, 1);
    chk("dn_c4_rdy", s2.rdy, 1);
    tick();
    chk("dn_c5_val", d2.val, 0);

    // upsize back-to-back packets: 0xA1(last) then 0xB2,0xC3(last)
    s0.val = 1; s0.data = 8'hA1; s0.last = 1;
    tick();
    s0.data = 8'hB2; s0.last = 0;
    #1;
    chk("b2b_src_rdy", s0.rdy, 1);
    chk("b2b_w0_data", d0.data, 16'h00A1);
    chk("b2b_w0_keep", d0.keep, 2'b01);
    chk("b2b_w0_last", d0.last, 1);
    tick();
    s0.data = 8'hC3; s0.last = 1;
    #1 chk("b2b_gap_val", d0.val, 0);
    tick();
    s0.val = 0; s0.last = 0;
    #1;
    chk("b2b_w1_val", d0.val, 1);
    chk("b2b_w1_data", d0.data, 16'hC3B2);
    chk("b2b_w1_keep", d0.keep, 2'b11);
    tick();

    // cfg_en dropped mid-word for 5 cycles
    s0.val = 1; s0.data = 8'h33; s0.last = 0;
    tick();
    en0 = 0; s0.data = 8'h44; s0.last = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("en_off_src_rdy", s0.rdy, 0);
      chk("en_off_dst_val", d0.val, 0);
      @(posedge clk);
    end
    #1;
    en0 = 1;
    #1 chk("en_on_src_rdy", s0.rdy, 1);
    tick();
    s0.val = 0; s0.last = 0;
    #1;
    chk("en_resume_val", d0.val, 1);
    chk("en_resume_data", d0.data, 16'h4433);
    chk("en_resume_keep", d0.keep, 2'b11);
    chk("en_resume_last", d0.last, 1);
    tick();

    // reset with a partial upsize word and a busy downsize word
    d2.rdy = 0;
    s0.val = 1; s0.data = 8'h55; s0.last = 0;
    s2.val = 1; s2.data = 16'hCAFE; s2.last = 1;
    tick();
    s0.val = 0; s2.val = 0; s2.last = 0;
    #1 chk("mid_busy", d2.val, 1);
    rst = 1;
    #1;
    chk("mid_rst_u2_val", d2.val, 0);
    chk("mid_rst_u2_data", d2.data, 0);
    chk("mid_rst_u2_last", d2.last, 0);
    chk("mid_rst_u2_keep", d2.keep, 0);
    chk("mid_rst_u0_rdy", s0.rdy, 0);
    chk("mid_rst_u0_val", d0.val, 0);
    #2 rst = 0;
    tick();
    s0.val = 1; s0.data = 8'h88; s0.last = 1;
    tick();
    s0.val = 0; s0.last = 0;
    #1;
    chk("post_rst_up_data", d0.data, 16'h0088);
    chk("post_rst_up_keep", d0.keep, 2'b01);
    chk("post_rst_up_last", d0.last, 1);
    tick();
    d2.rdy = 1;
    s2.val = 1; s2.data = 16'h0102; s2.last = 1;
    tick();
    s2.val = 0; s2.last = 0;
    #1;
    chk("post_rst_dn_d0", d2.data, 8'h02);
    chk("post_rst_dn_l0", d2.last, 0);
    tick();
    chk("post_rst_dn_d1", d2.data, 8'h01);
    chk("post_rst_dn_l1", d2.last, 1);
    tick();
    chk("post_rst_dn_idle", d2.val, 0);

    // 32->8 with random dst_rdy against a slice scoreboard
    sent = 0; got = 0; cyc = 0; stalled = 0;
    prev_data = 0; prev_last = 0;
    while (got < 4000 && cyc < 20000) begin
      if (!s3.val && sent < 1000) begin
        s3.val  = 1;
        s3.data = $urandom;
        s3.last = (sent % 4 == 3);
      end
      d3.rdy = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        chk("sb_hold_val", d3.val, 1);
        chk("sb_hold_data", d3.data, prev_data);
        chk("sb_hold_last", d3.last, prev_last);
      end
      src_go = s3.val && s3.rdy;
      dst_go = d3.val && d3.rdy;
      if (dst_go) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {d3.last, d3.data}, 9'h1FF ^ {d3.last, d3.data});
        end else begin
          exp_v = exp_q.pop_front();
          chk("sb_slice", {d3.last, d3.data}, exp_v);
        end
        got++;
      end
      if (src_go) begin
        w = s3.data;
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back({(s3.last && k == 3), w[k*8 +: 8]});
        end
        sent++;
      end
      stalled   = d3.val && !d3.rdy;
      prev_data = d3.data;
      prev_last = d3.last;
      tick();
      if (src_go) s3.val = 0;
      cyc++;
    end
    chk("sb_slices", got, 4000);
    chk("sb_words", sent, 1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
